// File: rtl/apu_issue_pkg.sv
// Shared types and default widths for the APU request issuer.
package apu_issue_pkg;

    localparam int unsigned NARGS_DEF    = 3;
    localparam int unsigned WOP_DEF      = 6;
    localparam int unsigned NDSFLAGS_DEF = 15;
    localparam int unsigned NUSFLAGS_DEF = 5;
    localparam int unsigned RADDR_W      = 6;

    typedef logic [RADDR_W-1:0] reg_addr_t;

    // Request stage: waiting for an op, or holding one until the APU grants it.
    typedef enum logic {
        S_IDLE = 1'b0,
        S_REQ  = 1'b1
    } req_state_e;

    // Request payload at the default widths.
    typedef struct packed {
        logic [NARGS_DEF-1:0][31:0] operands;
        logic [WOP_DEF-1:0]         op;
        logic [NDSFLAGS_DEF-1:0]    flags;
        reg_addr_t                  waddr;
    } apu_req_t;

endpackage

// File: rtl/apu_tag_fifo.sv
// In-order FIFO of destination registers for granted, unanswered APU ops.
// Entries and their valid bits are exported for hazard comparison.
module apu_tag_fifo
    import apu_issue_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_i,
    input  logic                            push_i,
    input  logic [RADDR_W-1:0]              push_data_i,
    input  logic                            pop_i,
    output logic [RADDR_W-1:0]              pop_data_o,
    output logic                            full_o,
    output logic                            empty_o,
    output logic [$clog2(DEPTH):0]          count_o,
    output logic [DEPTH-1:0][RADDR_W-1:0]   entries_o,
    output logic [DEPTH-1:0]                valid_o
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [DEPTH-1:0][RADDR_W-1:0] mem_q;
    logic [DEPTH-1:0]              valid_q;
    logic [PW-1:0]                 wr_ptr_q;
    logic [PW-1:0]                 rd_ptr_q;
    logic [CW-1:0]                 count_q;
    logic                          do_push;
    logic                          do_pop;

    assign full_o     = (count_q == CW'(DEPTH));
    assign empty_o    = (count_q == '0);
    assign do_push    = push_i && !full_o;
    assign do_pop     = pop_i && !empty_o;
    assign pop_data_o = mem_q[rd_ptr_q];
    assign count_o    = count_q;
    assign entries_o  = mem_q;
    assign valid_o    = valid_q;

    // Storage, power-of-two pointers (wrap by overflow), occupancy count.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mem_q    <= '0;
            valid_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q]   <= push_data_i;
                valid_q[wr_ptr_q] <= 1'b1;
                wr_ptr_q          <= wr_ptr_q + 1'b1;
            end
            if (do_pop) begin
                valid_q[rd_ptr_q] <= 1'b0;
                rd_ptr_q          <= rd_ptr_q + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/apu_req_issuer.sv
// Issues core ops to the APU with a req/gnt handshake, tracks outstanding
// ops in order, registers the writeback and flags register hazards.
module apu_req_issuer
    import apu_issue_pkg::*;
#(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned NARGS    = NARGS_DEF,
    parameter int unsigned WOP      = WOP_DEF,
    parameter int unsigned NDSFLAGS = NDSFLAGS_DEF,
    parameter int unsigned NUSFLAGS = NUSFLAGS_DEF
) (
    input  logic                        clk_i,
    input  logic                        rst_i,
    input  logic                        issue_valid_i,
    output logic                        issue_ready_o,
    input  logic [NARGS-1:0][31:0]      issue_operands_i,
    input  logic [WOP-1:0]              issue_op_i,
    input  logic [NDSFLAGS-1:0]         issue_flags_i,
    input  logic [RADDR_W-1:0]          issue_waddr_i,
    output logic                        apu_req_o,
    input  logic                        apu_gnt_i,
    output logic [NARGS-1:0][31:0]      apu_operands_o,
    output logic [WOP-1:0]              apu_op_o,
    output logic [NDSFLAGS-1:0]         apu_flags_o,
    input  logic                        apu_rvalid_i,
    input  logic [31:0]                 apu_rdata_i,
    input  logic [NUSFLAGS-1:0]         apu_rflags_i,
    output logic                        wb_valid_o,
    output logic [RADDR_W-1:0]          wb_waddr_o,
    output logic [31:0]                 wb_rdata_o,
    output logic [NUSFLAGS-1:0]         wb_rflags_o,
    input  logic [2:0][RADDR_W-1:0]     hzd_raddr_i,
    output logic                        hazard_o,
    output logic [$clog2(DEPTH):0]      outstanding_o,
    output logic                        busy_o,
    output logic                        proto_err_o
);

    localparam int unsigned CW = $clog2(DEPTH) + 1;
    localparam int unsigned PW = $clog2(DEPTH);

    req_state_e                     state_q, state_d;
    logic [NARGS-1:0][31:0]         operands_q;
    logic [WOP-1:0]                 op_q;
    logic [NDSFLAGS-1:0]            flags_q;
    logic [RADDR_W-1:0]             waddr_q;

    logic                           issue_fire;
    logic                           grant;
    logic [CW:0]                    inflight;

    logic [RADDR_W-1:0]             fifo_head;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [CW-1:0]                  fifo_count;
    logic [DEPTH-1:0][RADDR_W-1:0]  fifo_entries;
    logic [DEPTH-1:0]               fifo_valid;

    logic                           wb_valid_q;
    logic [RADDR_W-1:0]             wb_waddr_q;
    logic [31:0]                    wb_rdata_q;
    logic [NUSFLAGS-1:0]            wb_rflags_q;
    logic                           proto_err_q;
    logic                           pop_ok;

    // A held request counts against DEPTH: it will occupy a slot once granted.
    assign inflight      = {1'b0, fifo_count} + (CW+1)'(state_q == S_REQ);
    // Gated by rst_i so no handshake is accepted while reset is asserted.
    assign issue_ready_o = !rst_i && ((state_q == S_IDLE) || apu_gnt_i)
                           && (inflight < (CW+1)'(DEPTH));
    assign issue_fire    = issue_valid_i && issue_ready_o;
    assign grant         = (state_q == S_REQ) && apu_gnt_i;
    assign pop_ok        = apu_rvalid_i && !fifo_empty;

    apu_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .push_i      (grant),
        .push_data_i (waddr_q),
        .pop_i       (apu_rvalid_i),
        .pop_data_o  (fifo_head),
        .full_o      (fifo_full),
        .empty_o     (fifo_empty),
        .count_o     (fifo_count),
        .entries_o   (fifo_entries),
        .valid_o     (fifo_valid)
    );

    // Request stage state register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    // Next state: a grant without a same-cycle issue drops back to IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (issue_fire) state_d = S_REQ;
            S_REQ:   if (apu_gnt_i && !issue_fire) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Held payload, replaced on every accepted issue.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            operands_q <= '0;
            op_q       <= '0;
            flags_q    <= '0;
            waddr_q    <= '0;
        end else if (issue_fire) begin
            operands_q <= issue_operands_i;
            op_q       <= issue_op_i;
            flags_q    <= issue_flags_i;
            waddr_q    <= issue_waddr_i;
        end
    end

    // Registered writeback and sticky protocol error.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wb_valid_q  <= 1'b0;
            wb_waddr_q  <= '0;
            wb_rdata_q  <= '0;
            wb_rflags_q <= '0;
            proto_err_q <= 1'b0;
        end else begin
            wb_valid_q <= pop_ok;
            if (pop_ok) begin
                wb_waddr_q  <= fifo_head;
                wb_rdata_q  <= apu_rdata_i;
                wb_rflags_q <= apu_rflags_i;
            end
            if ((apu_rvalid_i && fifo_empty) || (grant && fifo_full))
                proto_err_q <= 1'b1;
        end
    end

    // Hazard: any source matches a pending destination (in FIFO or held).
    always_comb begin
        hazard_o = 1'b0;
        for (int unsigned s = 0; s < 3; s++) begin
            if ((state_q == S_REQ) && (waddr_q == hzd_raddr_i[s[1:0]]))
                hazard_o = 1'b1;
            for (int unsigned e = 0; e < DEPTH; e++) begin
                if (fifo_valid[e[PW-1:0]] && (fifo_entries[e[PW-1:0]] == hzd_raddr_i[s[1:0]]))
                    hazard_o = 1'b1;
            end
        end
    end

    assign apu_req_o      = (state_q == S_REQ);
    assign apu_operands_o = operands_q;
    assign apu_op_o       = op_q;
    assign apu_flags_o    = flags_q;
    assign wb_valid_o     = wb_valid_q;
    assign wb_waddr_o     = wb_waddr_q;
    assign wb_rdata_o     = wb_rdata_q;
    assign wb_rflags_o    = wb_rflags_q;
    assign outstanding_o  = fifo_count;
    assign busy_o         = (state_q == S_REQ) || (fifo_count != '0) || wb_valid_q;
    assign proto_err_o    = proto_err_q;

endmodule

// File: tb/tb_apu_req_issuer.sv
// Directed testbench for apu_req_issuer at default parameters.
module tb_apu_req_issuer;

    logic             clk;
    logic             rst;
    logic             issue_valid;
    logic             issue_ready;
    logic [2:0][31:0] issue_operands;
    logic [5:0]       issue_op;
    logic [14:0]      issue_flags;
    logic [5:0]       issue_waddr;
    logic             apu_req;
    logic             apu_gnt;
    logic [2:0][31:0] apu_operands;
    logic [5:0]       apu_op;
    logic [14:0]      apu_flags;
    logic             apu_rvalid;
    logic [31:0]      apu_rdata;
    logic [4:0]       apu_rflags;
    logic             wb_valid;
    logic [5:0]       wb_waddr;
    logic [31:0]      wb_rdata;
    logic [4:0]       wb_rflags;
    logic [2:0][5:0]  hzd_raddr;
    logic             hazard;
    logic [2:0]       outstanding;
    logic             busy;
    logic             proto_err;

    int checks = 0;
    int errors = 0;

    apu_req_issuer #(.DEPTH(4)) dut (
        .clk_i            (clk),
        .rst_i            (rst),
        .issue_valid_i    (issue_valid),
        .issue_ready_o    (issue_ready),
        .issue_operands_i (issue_operands),
        .issue_op_i       (issue_op),
        .issue_flags_i    (issue_flags),
        .issue_waddr_i    (issue_waddr),
        .apu_req_o        (apu_req),
        .apu_gnt_i        (apu_gnt),
        .apu_operands_o   (apu_operands),
        .apu_op_o         (apu_op),
        .apu_flags_o      (apu_flags),
        .apu_rvalid_i     (apu_rvalid),
        .apu_rdata_i      (apu_rdata),
        .apu_rflags_i     (apu_rflags),
        .wb_valid_o       (wb_valid),
        .wb_waddr_o       (wb_waddr),
        .wb_rdata_o       (wb_rdata),
        .wb_rflags_o      (wb_rflags),
        .hzd_raddr_i      (hzd_raddr),
        .hazard_o         (hazard),
        .outstanding_o    (outstanding),
        .busy_o           (busy),
        .proto_err_o      (proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        tick;
        tick;
        checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL rst_req: got %0h exp 0", apu_req); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL rst_outstanding: got %0d exp 0", outstanding); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0h exp 0", busy); end
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL rst_wb_valid: got %0h exp 0", wb_valid); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL rst_proto_err: got %0h exp 0", proto_err); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0h exp 0", issue_ready); end
        rst = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL post_rst_ready: got %0h exp 1", issue_ready); end
        tick;
    endtask

    task automatic test_single_op;
        issue_valid = 1'b1;
        issue_waddr = 6'd5;
        issue_op = 6'h2A;
        issue_operands = 96'h00000003_00000002_00000001;
        issue_flags = 15'h1234;
        #1;
        checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %0h exp 1", issue_ready); end
        tick;
        issue_valid = 1'b0;
        issue_op = 6'h00;
        issue_operands = '0;
        issue_flags = '0;
        #1;
        checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL single_req_c1: got %0h exp 1", apu_req); end
        checks++; if (apu_op !== 6'h2A) begin errors++; $display("FAIL single_op_c1: got %0h exp 2a", apu_op); end
        checks++; if (apu_operands !== 96'h00000003_00000002_00000001) begin errors++; $display("FAIL single_operands: got %0h exp 300000002_00000001", apu_operands); end
        checks++; if (apu_flags !== 15'h1234) begin errors++; $display("FAIL single_flags: got %0h exp 1234", apu_flags); end
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL single_ready_req: got %0h exp 0", issue_ready); end
        tick;
        checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL single_req_c2: got %0h exp 1", apu_req); end
        checks++; if (apu_op !== 6'h2A) begin errors++; $display("FAIL single_op_c2: got %0h exp 2a", apu_op); end
        apu_gnt = 1'b1;
        tick;
        apu_gnt = 1'b0;
        checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL single_req_after_gnt: got %0h exp 0", apu_req); end
        checks++; if (outstanding !== 3'd1) begin errors++; $display("FAIL single_outstanding: got %0d exp 1", outstanding); end
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %0h exp 1", busy); end
        tick;
        tick;
        apu_rvalid = 1'b1;
        apu_rdata = 32'h3F800000;
        apu_rflags = 5'h11;
        tick;
        apu_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL single_wb_valid: got %0h exp 1", wb_valid); end
        checks++; if (wb_waddr !== 6'd5) begin errors++; $display("FAIL single_wb_waddr: got %0d exp 5", wb_waddr); end
        checks++; if (wb_rdata !== 32'h3F800000) begin errors++; $display("FAIL single_wb_rdata: got %0h exp 3f800000", wb_rdata); end
        checks++; if (wb_rflags !== 5'h11) begin errors++; $display("FAIL single_wb_rflags: got %0h exp 11", wb_rflags); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL single_drained: got %0d exp 0", outstanding); end
        tick;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL single_wb_pulse: got %0h exp 0", wb_valid); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL single_idle_busy: got %0h exp 0", busy); end
    endtask

    task automatic test_back_to_back;
        apu_gnt = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            issue_valid = 1'b1;
            issue_waddr = 6'(k);
            #1;
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0h exp 1", k, issue_ready); end
            tick;
            checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL b2b_req_%0d: got %0h exp 1", k, apu_req); end
        end
        issue_valid = 1'b0;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_at3: got %0h exp 0", issue_ready); end
        tick;
        apu_gnt = 1'b0;
        checks++; if (outstanding !== 3'd4) begin errors++; $display("FAIL b2b_outstanding: got %0d exp 4", outstanding); end
        checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL b2b_req_done: got %0h exp 0", apu_req); end
        issue_valid = 1'b1;
        issue_waddr = 6'd9;
        #1;
        checks++; if (issue_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_full: got %0h exp 0", issue_ready); end
        issue_valid = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            apu_rvalid = 1'b1;
            apu_rdata = 32'h100 + 32'(k);
            tick;
            apu_rvalid = 1'b0;
            checks++; if (wb_valid !== 1'b1) begin errors++; $display("FAIL b2b_wb_valid_%0d: got %0h exp 1", k, wb_valid); end
            checks++; if (wb_waddr !== 6'(k)) begin errors++; $display("FAIL b2b_wb_waddr_%0d: got %0d exp %0d", k, wb_waddr, k); end
            checks++; if (wb_rdata !== 32'h100 + 32'(k)) begin errors++; $display("FAIL b2b_wb_rdata_%0d: got %0h exp %0h", k, wb_rdata, 32'h100 + 32'(k)); end
            checks++; if (issue_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_drain_%0d: got %0h exp 1", k, issue_ready); end
        end
        tick;
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL b2b_drained: got %0d exp 0", outstanding); end
    endtask

    task automatic test_push_pop_same;
        issue_valid = 1'b1;
        issue_waddr = 6'd10;
        tick;
        apu_gnt = 1'b1;
        issue_waddr = 6'd11;
        tick;
        issue_waddr = 6'd12;
        tick;
        issue_valid = 1'b0;
        apu_gnt = 1'b0;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL pp_pre_outstanding: got %0d exp 2", outstanding); end
        apu_gnt = 1'b1;
        apu_rvalid = 1'b1;
        apu_rdata = 32'hA;
        tick;
        apu_gnt = 1'b0;
        checks++; if (outstanding !== 3'd2) begin errors++; $display("FAIL pp_same_cycle: got %0d exp 2", outstanding); end
        checks++; if (wb_waddr !== 6'd10) begin errors++; $display("FAIL pp_wb0_waddr: got %0d exp 10", wb_waddr); end
        checks++; if (wb_rdata !== 32'hA) begin errors++; $display("FAIL pp_wb0_rdata: got %0h exp a", wb_rdata); end
        apu_rdata = 32'hB;
        tick;
        checks++; if (wb_waddr !== 6'd11) begin errors++; $display("FAIL pp_wb1_waddr: got %0d exp 11", wb_waddr); end
        apu_rdata = 32'hC;
        tick;
        apu_rvalid = 1'b0;
        checks++; if (wb_waddr !== 6'd12) begin errors++; $display("FAIL pp_wb2_waddr: got %0d exp 12", wb_waddr); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL pp_drained: got %0d exp 0", outstanding); end
        tick;
    endtask

    task automatic test_hazard;
        hzd_raddr = '0;
        hzd_raddr[0] = 6'd7;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hzd_none: got %0h exp 0", hazard); end
        issue_valid = 1'b1;
        issue_waddr = 6'd7;
        tick;
        issue_valid = 1'b0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hzd_held: got %0h exp 1", hazard); end
        apu_gnt = 1'b1;
        tick;
        apu_gnt = 1'b0;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hzd_fifo: got %0h exp 1", hazard); end
        hzd_raddr[0] = 6'd8;
        #1;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hzd_other_reg: got %0h exp 0", hazard); end
        hzd_raddr[0] = 6'd0;
        hzd_raddr[2] = 6'd7;
        apu_rvalid = 1'b1;
        apu_rdata = 32'h7;
        #1;
        checks++; if (hazard !== 1'b1) begin errors++; $display("FAIL hzd_rvalid_cycle: got %0h exp 1", hazard); end
        tick;
        apu_rvalid = 1'b0;
        checks++; if (hazard !== 1'b0) begin errors++; $display("FAIL hzd_dropped: got %0h exp 0", hazard); end
        hzd_raddr = '0;
        tick;
    endtask

    task automatic test_spurious;
        apu_rvalid = 1'b1;
        apu_rdata = 32'hDEAD;
        tick;
        apu_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL spur_wb_valid: got %0h exp 0", wb_valid); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL spur_proto_err: got %0h exp 1", proto_err); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL spur_outstanding: got %0d exp 0", outstanding); end
        tick;
        tick;
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL spur_sticky: got %0h exp 1", proto_err); end
    endtask

    task automatic test_reset_midflight;
        issue_valid = 1'b1;
        issue_waddr = 6'd20;
        tick;
        apu_gnt = 1'b1;
        issue_waddr = 6'd21;
        tick;
        issue_waddr = 6'd22;
        tick;
        issue_waddr = 6'd23;
        tick;
        issue_valid = 1'b0;
        apu_gnt = 1'b0;
        checks++; if (outstanding !== 3'd3) begin errors++; $display("FAIL mid_outstanding: got %0d exp 3", outstanding); end
        checks++; if (apu_req !== 1'b1) begin errors++; $display("FAIL mid_req: got %0h exp 1", apu_req); end
        #2;
        rst = 1'b1;
        #1;
        checks++; if (apu_req !== 1'b0) begin errors++; $display("FAIL mid_rst_req: got %0h exp 0", apu_req); end
        checks++; if (outstanding !== 3'd0) begin errors++; $display("FAIL mid_rst_outstanding: got %0d exp 0", outstanding); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %0h exp 0", busy); end
        checks++; if (proto_err !== 1'b0) begin errors++; $display("FAIL mid_rst_proto_err: got %0h exp 0", proto_err); end
        tick;
        rst = 1'b0;
        tick;
        apu_rvalid = 1'b1;
        apu_rdata = 32'h55;
        tick;
        apu_rvalid = 1'b0;
        checks++; if (wb_valid !== 1'b0) begin errors++; $display("FAIL mid_late_wb: got %0h exp 0", wb_valid); end
        checks++; if (proto_err !== 1'b1) begin errors++; $display("FAIL mid_late_err: got %0h exp 1", proto_err); end
    endtask

    initial begin
        rst = 1'b1;
        issue_valid = 1'b0;
        issue_operands = '0;
        issue_op = '0;
        issue_flags = '0;
        issue_waddr = '0;
        apu_gnt = 1'b0;
        apu_rvalid = 1'b0;
        apu_rdata = '0;
        apu_rflags = '0;
        hzd_raddr = '0;
        test_reset;
        test_single_op;
        test_back_to_back;
        test_push_pop_same;
        test_hazard;
        test_spurious;
        test_reset_midflight;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/apu_req_issuer.md
APU_REQ_ISSUER -- requirements
Module: apu_req_issuer

Interface
REQ-001 Parameter DEPTH, default 4: maximum outstanding granted-but-unanswered APU ops, power of two, at least 2.
REQ-002 Parameter NARGS, default 3: operand count; WOP default 6: op width; NDSFLAGS default 15: downstream flag width; NUSFLAGS default 5: upstream flag width.
REQ-003 clk_i  in  1  single clock, all state rising-edge.
REQ-004 rst_i  in  1  asynchronous, active-high reset.
REQ-005 issue_valid_i / issue_ready_o  in/out  1/1  core-side op handshake.
REQ-006 issue_operands_i  in  NARGS x 32  operands; issue_op_i  in  WOP  op; issue_flags_i  in  NDSFLAGS  flags; issue_waddr_i  in  6  destination register.
REQ-007 apu_req_o / apu_gnt_i  out/in  1/1  APU request handshake.
REQ-008 apu_operands_o  out  NARGS x 32; apu_op_o  out  WOP; apu_flags_o  out  NDSFLAGS: held request payload.
REQ-009 apu_rvalid_i  in  1; apu_rdata_i  in  32; apu_rflags_i  in  NUSFLAGS: in-order APU response, no back-pressure.
REQ-010 wb_valid_o  out  1; wb_waddr_o  out  6; wb_rdata_o  out  32; wb_rflags_o  out  NUSFLAGS: registered writeback.
REQ-011 hzd_raddr_i  in  3 x 6: source registers to check; hazard_o  out  1: a source register is pending.
REQ-012 outstanding_o  out  clog2(DEPTH)+1: in-flight count; busy_o  out  1; proto_err_o  out  1: sticky error flag.

Function
REQ-013 Request stage states: IDLE and REQ; an issue handshake (valid and ready) registers the payload and the destination register, and the stage enters REQ.
REQ-014 In REQ, apu_req_o is 1 and the payload is stable until apu_gnt_i; the request is never withdrawn.
REQ-015 On a grant, the held destination register is pushed into the in-order tag FIFO.
REQ-016 On a grant, the stage returns to IDLE unless a new issue handshake occurs in the same cycle, in which case it stays in REQ with the new payload (back-to-back, one op per cycle).
REQ-017 issue_ready_o = (state IDLE or apu_gnt_i) and (outstanding + pending request < DEPTH); the combinational gnt-to-ready path is permitted.
REQ-018 apu_rvalid_i pops the FIFO head; the next cycle wb_valid_o is 1 with the popped destination register, apu_rdata_i and apu_rflags_i, each registered.
REQ-019 A push and a pop in the same cycle leave outstanding_o unchanged; FIFO pointers wrap modulo DEPTH.
REQ-020 apu_rvalid_i with an empty FIFO is dropped: no wb_valid_o pulse, and proto_err_o is set until reset.
REQ-021 A grant with a full FIFO cannot occur by REQ-017; if it does, proto_err_o is set and the push is dropped.
REQ-022 hazard_o, combinational: any hzd_raddr_i equals any valid FIFO entry's destination register, or the held destination register while in REQ.
REQ-023 busy_o = REQ state or outstanding_o non-zero or wb_valid_o.

Reset
REQ-024 On reset: state IDLE, FIFO empty, pointers 0, and all outputs 0.
REQ-025 Reset during operation discards every pending and outstanding op; responses after reset are then treated per REQ-020.

Structure
REQ-026 Package apu_issue_pkg holds NARGS/WOP/NDSFLAGS/NUSFLAGS defaults, the 6-bit register-address type and the request payload struct.
REQ-027 Sub-module apu_tag_fifo: DEPTH-entry register FIFO with per-entry valid vector exported for hazard comparison.

Verification
REQ-028 Single op: waddr 5, gnt 2 cycles after req, rvalid 3 cycles later with rdata 0x3F800000 -> apu_req_o held stable 2 cycles; wb_valid_o one cycle after rvalid, wb_waddr_o 5, wb_rdata_o 0x3F800000.
REQ-029 Back-to-back: 4 ops waddr 1..4, gnt tied 1 -> 4 consecutive grants; outstanding_o reaches 4; issue_ready_o 0 until the first rvalid.
REQ-030 Same-cycle grant and rvalid at outstanding 2 -> outstanding_o stays 2; writebacks appear in issue order.
REQ-031 Hazard: op waddr 7 outstanding, hzd_raddr_i {7,0,0} -> hazard_o 1; it drops the cycle after its rvalid.
REQ-032 Spurious rvalid with FIFO empty -> no wb_valid_o; proto_err_o 1 and held until rst_i.
REQ-033 rst_i asserted with 3 ops outstanding and REQ active -> apu_req_o, outstanding_o and busy_o 0 immediately, without waiting for a clock edge.
